// File: rtl/logic_accum_pkg.sv
// Shared constants for the bitwise fold accumulator.
// Holds the operation encodings seen on in_op/out_op and the FSM state
// encodings used by bitwise_logic_accum.
package logic_accum_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ACCUM = 2'b01;
  localparam logic [1:0] S_HOLD  = 2'b10;

endpackage

// File: rtl/bitwise_logic_op.sv
// Combinational two-operand bitwise operator.
// Ports:
//   a, b : WIDTH-bit operands
//   op   : 2-bit operation select (AND/OR/XOR/NOR)
//   y    : WIDTH-bit result
// NOR is evaluated as OR here: the fold keeps a plain OR running total and
// the single inversion is applied once when the result is presented.
module bitwise_logic_op
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_accum.sv
// Multi-operand bitwise fold accumulator.
// Accepts a stream of operand beats on a valid/ready input, folds them with
// the operation chosen on the first beat, and returns one registered result
// per transaction on a valid/ready output.
// Ports:
//   clk, reset            : clock (rising edge), async active-high reset
//   in_valid/in_ready     : operand handshake (in_ready is combinational)
//   in_data, in_op, in_last : operand, op select (first beat), final-beat flag
//   out_valid/out_ready   : result handshake
//   out_data, out_op, out_count : folded result, op used, operand count
//
// state   | meaning
// S_IDLE  | waiting for the first beat of a transaction
// S_ACCUM | folding further beats into the accumulator
// S_HOLD  | result presented, waiting for the consumer
module bitwise_logic_accum
  import logic_accum_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_OPS = 4,
  localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_OPS);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_op;
  logic [CNT_W-1:0] r_out_count;

  logic             w_beat;
  logic             w_first;
  logic [WIDTH-1:0] w_op_result;
  logic [WIDTH-1:0] w_fold;
  logic [1:0]       w_op_cur;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_op    = r_out_op;
  assign out_count = r_out_count;

  assign w_beat  = in_valid && in_ready;
  assign w_first = (r_state == S_IDLE);

  bitwise_logic_op #(.WIDTH(WIDTH)) u_op (
    .a  (r_acc),
    .b  (in_data),
    .op (r_op),
    .y  (w_op_result)
  );

  // The first beat seeds the accumulator directly so nothing from a previous
  // transaction can leak into the new result.
  assign w_fold     = w_first ? in_data : w_op_result;
  assign w_op_cur   = w_first ? in_op : r_op;
  assign w_cnt_next = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_done     = in_last || (w_cnt_next == MAX_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_op        <= OP_AND;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_op    <= OP_AND;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_fold;
            r_op  <= w_op_cur;
            r_cnt <= w_cnt_next;
            if (w_done) begin
              // Result registers load with the final fold so out_valid rises
              // the cycle after the last beat.
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_out_data  <= (w_op_cur == OP_NOR) ? ~w_fold : w_fold;
              r_out_op    <= w_op_cur;
              r_out_count <= w_cnt_next;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_logic_accum.sv
module tb_bitwise_logic_accum;

  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 4;
  localparam int CNT_W   = $clog2(NUM_OPS + 1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;
  logic [CNT_W-1:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;

  bitwise_logic_accum #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: offer one beat, it is accepted at the next posedge
  // (in_ready checked), returns at the following negedge.
  task automatic send(input logic [7:0] d, input logic [1:0] op, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    chk("in_ready_on_beat", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge right after the final beat: check the result,
  // complete the output handshake, check return to idle.
  task automatic take(input string tag, input logic [7:0] d, input logic [1:0] op,
                      input logic [2:0] cnt);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_op"},    32'(out_op),    32'(op));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    chk({tag, "_busy"},  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_set"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_op",    32'(out_op),    32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    reset = 1'b0;
    @(negedge clk);

    // OR of four beats, count limit terminates
    send(8'h01, 2'b01, 1'b0);
    send(8'h02, 2'b01, 1'b0);
    send(8'h04, 2'b01, 1'b0);
    chk("or_not_yet_valid", 32'(out_valid), 32'd0);
    send(8'h08, 2'b01, 1'b0);
    take("or4", 8'h0F, 2'b01, 3'd4);

    // AND with early in_last, in_op on 2nd beat ignored
    send(8'hF0, 2'b00, 1'b0);
    send(8'h3C, 2'b10, 1'b1);
    take("and2", 8'h30, 2'b00, 3'd2);

    // NOR single beat
    send(8'hA5, 2'b11, 1'b1);
    take("nor1", 8'h5A, 2'b11, 3'd1);

    // XOR with back-pressure; a beat offered during HOLD is refused
    send(8'hFF, 2'b10, 1'b0);
    send(8'h0F, 2'b10, 1'b0);
    send(8'hF0, 2'b10, 1'b0);
    send(8'h55, 2'b10, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_op    = 2'b01;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("xor_hold_data",  32'(out_data),  32'h55);
      chk("xor_hold_ready", 32'(in_ready),  32'd0);
      chk("xor_hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    take("xor4", 8'h55, 2'b10, 3'd4);

    // Reset mid-ACCUM after two beats
    send(8'h0C, 2'b01, 1'b0);
    send(8'h30, 2'b01, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(8'h11, 2'b01, 1'b0);
    send(8'h22, 2'b01, 1'b1);
    take("post_rst", 8'h33, 2'b01, 3'd2);

    // Reset during HOLD clears out_valid and raises in_ready without a clock edge
    send(8'h81, 2'b00, 1'b1);
    in_valid = 1'b0;
    chk("hold_pre_rdy", 32'(in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("holdrst_valid", 32'(out_valid), 32'd0);
    chk("holdrst_ready", 32'(in_ready),  32'd1);
    chk("holdrst_data",  32'(out_data),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: new first beat in the cycle after the handshake
    send(8'h3C, 2'b10, 1'b0);
    send(8'h0F, 2'b10, 1'b1);
    take("b2b_a", 8'h33, 2'b10, 3'd2);
    send(8'hAA, 2'b00, 1'b1);
    take("b2b_b", 8'hAA, 2'b00, 3'd1);
    send(8'h0F, 2'b11, 1'b0);
    send(8'hF0, 2'b00, 1'b1);
    take("nor2", 8'h00, 2'b11, 3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
